// File: rtl/systolic_run_sequencer.sv
// Sequencer for one systolic matrix-multiply pass: weight load, activation stream, drain.
// Optional stall counter output enabled by defining SEQ_PERF_CNT_EN.
module systolic_run_sequencer #(
    parameter int DIM       = 8,
    parameter int CNT_WIDTH = 16,
    parameter int ROW_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ROW_WIDTH-1:0] cfg_wrows,
    input  logic [CNT_WIDTH-1:0] cfg_k,
    input  logic                 act_avail,
    output logic                 busy,
    output logic                 cfg_lock,
    output logic                 w_load_en,
    output logic [ROW_WIDTH-1:0] w_row_idx,
    output logic                 act_en,
    output logic [CNT_WIDTH-1:0] act_idx,
    output logic                 drain_en,
    output logic                 done,
    output logic                 err
`ifdef SEQ_PERF_CNT_EN
   ,output logic [CNT_WIDTH-1:0] stall_cycles
`endif
);

    localparam int DRAIN_LEN = 2 * DIM - 1;
    localparam int DW        = $clog2(2 * DIM);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t               state;
    state_t               state_nx;
    logic [ROW_WIDTH-1:0] wrows_q;
    logic [CNT_WIDTH-1:0] k_q;
    logic [DW-1:0]        drain_cnt;
    logic                 err_q;
    logic                 legal;
    logic                 capture;
    logic                 last_row;
    logic                 last_act;
    logic                 last_drain;

    assign legal = (cfg_wrows != '0) && (cfg_wrows <= ROW_WIDTH'(DIM)) && (cfg_k != '0);
    assign capture = (state == IDLE) && start && !abort && legal;
    assign last_row = (w_row_idx == wrows_q - ROW_WIDTH'(1));
    assign last_act = act_avail && (act_idx == k_q - CNT_WIDTH'(1));
    assign last_drain = (drain_cnt == DW'(DRAIN_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // abort outranks every other transition out of a busy state
    always_comb begin
        state_nx = state;
        if (abort && state != IDLE) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (capture) state_nx = LOAD_W;
                LOAD_W:  if (last_row) state_nx = STREAM;
                STREAM:  if (last_act) state_nx = DRAIN;
                DRAIN:   if (last_drain) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign cfg_lock  = busy;
    assign w_load_en = (state == LOAD_W);
    assign act_en    = (state == STREAM) && act_avail;
    assign drain_en  = (state == DRAIN);
    assign done      = (state == DONE);
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrows_q   <= '0;
            k_q       <= '0;
            w_row_idx <= '0;
            act_idx   <= '0;
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && start && !abort && !legal;
            if (capture) begin
                wrows_q   <= cfg_wrows;
                k_q       <= cfg_k;
                w_row_idx <= '0;
                act_idx   <= '0;
                drain_cnt <= '0;
            end else begin
                if (state == LOAD_W && !last_row) begin
                    w_row_idx <= w_row_idx + ROW_WIDTH'(1);
                end
                if (act_en) begin
                    act_idx <= act_idx + CNT_WIDTH'(1);
                end
                if (state == DRAIN) begin
                    drain_cnt <= drain_cnt + DW'(1);
                end
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (capture) begin
            stall_cycles <= '0;
        end else if (state == STREAM && !act_avail && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end
`else
    // build without the stall counter
`endif

endmodule

// File: tb/tb_systolic_run_sequencer.sv
// Randomised and directed bench for systolic_run_sequencer against a queue-based pass model.
// Define SEQ_PERF_CNT_EN to also check the stall counter.
module tb_systolic_run_sequencer;

    localparam int DIM = 4;
    localparam int CW  = 16;
    localparam int RW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [RW-1:0] cfg_wrows = '0;
    logic [CW-1:0] cfg_k = '0;
    logic          act_avail = 1'b0;
    logic          busy, cfg_lock, w_load_en, act_en, drain_en, done, err;
    logic [RW-1:0] w_row_idx;
    logic [CW-1:0] act_idx;
`ifdef SEQ_PERF_CNT_EN
    logic [CW-1:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    systolic_run_sequencer #(.DIM(DIM), .CNT_WIDTH(CW), .ROW_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_wrows(cfg_wrows), .cfg_k(cfg_k), .act_avail(act_avail),
        .busy(busy), .cfg_lock(cfg_lock), .w_load_en(w_load_en),
        .w_row_idx(w_row_idx), .act_en(act_en), .act_idx(act_idx),
        .drain_en(drain_en), .done(done), .err(err)
`ifdef SEQ_PERF_CNT_EN
       ,.stall_cycles(stall_cycles)
`endif
    );

    // The pass is a list of pending cycles; STREAM stays at the head until k accepts.
    typedef enum {K_LOAD, K_STREAM, K_DRAIN, K_DONE} kind_e;
    typedef struct {kind_e kind; int val;} item_t;

    item_t q[$];
    int    acc = 0;
    int    stall = 0;
    int    err_exp = 0;
    int    errors = 0;
    int    checks = 0;
    int    cnum = 0;
    int    done_seen = 0;
    int    act_seen = 0;
    int    err_seen = 0;
    int    last_done = -1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cnum, got, exp);
        end
    endtask

    task automatic compare();
        bit    act;
        kind_e k;
        act = (q.size() != 0);
        k = act ? q[0].kind : K_LOAD;
        chk("busy", busy, act);
        chk("cfg_lock", cfg_lock, act);
        chk("w_load_en", w_load_en, act && k == K_LOAD);
        if (act && k == K_LOAD) chk("w_row_idx", w_row_idx, q[0].val);
        chk("act_en", act_en, act && k == K_STREAM && act_avail);
        if (act && k == K_STREAM && act_avail) chk("act_idx", act_idx, acc);
        chk("drain_en", drain_en, act && k == K_DRAIN);
        chk("done", done, act && k == K_DONE);
        chk("err", err, err_exp);
`ifdef SEQ_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, stall);
`endif
        if (done) begin
            done_seen++;
            last_done = cnum;
        end
        if (act_en) act_seen++;
        if (err) err_seen++;
    endtask

    task automatic model_step();
        int e;
        e = 0;
        if (q.size() != 0) begin
            if (q[0].kind == K_STREAM && !act_avail && stall < (1 << CW) - 1) stall++;
            if (abort) begin
                q.delete();
            end else if (q[0].kind == K_STREAM) begin
                if (act_avail) begin
                    acc++;
                    if (acc == q[0].val) void'(q.pop_front());
                end
            end else begin
                void'(q.pop_front());
            end
        end else if (start && !abort) begin
            if (cfg_wrows >= 1 && cfg_wrows <= DIM && cfg_k != 0) begin
                for (int i = 0; i < int'(cfg_wrows); i++) q.push_back('{K_LOAD, i});
                q.push_back('{K_STREAM, int'(cfg_k)});
                for (int i = 0; i < 2 * DIM - 1; i++) q.push_back('{K_DRAIN, i});
                q.push_back('{K_DONE, 0});
                acc = 0;
                stall = 0;
            end else begin
                e = 1;
            end
        end
        err_exp = e;
    endtask

    task automatic cyc(input bit s, input bit a, input int wr, input int k, input bit av);
        @(negedge clk);
        start = s;
        abort = a;
        cfg_wrows = RW'(wr);
        cfg_k = CW'(k);
        act_avail = av;
        #1 compare();
        @(posedge clk);
        model_step();
        cnum++;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        q.delete();
        err_exp = 0;
        stall = 0;
        #1 compare();
        @(posedge clk);
        cnum++;
        @(negedge clk);
        #1 compare();
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        int d0;
        int a0;
        #12 compare();
        @(negedge clk);
        rst = 1'b0;

        // plan 1: no stalls
        t0 = cnum;
        cyc(1, 0, 4, 3, 1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 4, 3, 1);
        chk("p1_done_cycle", last_done - t0, 15);

        // plan 2: two-cycle stall after the first vector
        t0 = cnum;
        cyc(1, 0, 4, 3, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 4, 3, 1);
        cyc(0, 0, 4, 3, 1);
        cyc(0, 0, 4, 3, 0);
        cyc(0, 0, 4, 3, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 4, 3, 1);
        chk("p2_done_cycle", last_done - t0, 17);
`ifdef SEQ_PERF_CNT_EN
        chk("p2_stall_lit", stall_cycles, 2);
`endif

        // plan 3: illegal configurations
        a0 = err_seen;
        cyc(1, 0, 0, 3, 1);
        cyc(0, 0, 0, 3, 1);
        cyc(1, 0, 5, 3, 1);
        cyc(0, 0, 0, 3, 1);
        cyc(1, 0, 4, 0, 1);
        cyc(0, 0, 0, 3, 1);
        chk("p3_err_count", err_seen - a0, 3);

        // plan 4: abort in STREAM at act_idx 1, then a full pass
        d0 = done_seen;
        cyc(1, 0, 2, 4, 1);
        cyc(0, 0, 2, 4, 1);
        cyc(0, 0, 2, 4, 1);
        cyc(0, 0, 2, 4, 1);
        cyc(0, 1, 2, 4, 0);
        cyc(0, 0, 2, 4, 1);
        chk("p4_no_done", done_seen - d0, 0);
        t0 = cnum;
        cyc(1, 0, 2, 2, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 2, 2, 1);
        chk("p4_done_cycle", last_done - t0, 1 + 2 + 2 + 7);

        // plan 5: cfg change in LOAD_W, start during DRAIN
        d0 = done_seen;
        a0 = act_seen;
        cyc(1, 0, 3, 3, 1);
        cyc(0, 0, 3, 9, 1);
        cyc(0, 0, 3, 9, 1);
        cyc(0, 0, 3, 9, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 3, 9, 1);
        cyc(1, 0, 3, 9, 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 3, 9, 1);
        chk("p5_act_count", act_seen - a0, 3);
        chk("p5_done_count", done_seen - d0, 1);

        // plan 6: async reset mid-DRAIN
        d0 = done_seen;
        cyc(1, 0, 2, 1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 2, 1, 1);
        async_reset();
        for (int i = 0; i < 10; i++) cyc(0, 0, 2, 1, 1);
        chk("p6_no_done", done_seen - d0, 0);

        // largest k is legal
        a0 = err_seen;
        cyc(1, 0, 1, 32'hFFFF, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 1);
        chk("kmax_busy", busy, 1);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        chk("kmax_no_err", err_seen - a0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 8) == 0, ($urandom % 40) == 0,
                $urandom_range(0, DIM + 1), $urandom_range(0, 6),
                ($urandom % 4) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
